// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with a one-byte holding register.
// The serial pin is double-flopped, the frame is sampled mid-bit using a
// per-bit cycle counter, and the received byte is offered on a valid/ready
// handshake. A stop bit sampled low reports a framing error and parks the
// receiver until the line returns high, so a stuck-low line cannot produce
// a stream of bogus frames.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Synchronizer stages; idle-high so reset looks like an idle line.
    logic s1_q;
    logic s2_q;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    // Stop-bit outcome for the current cycle, consumed by the holding logic.
    logic                 deliver_s;
    logic                 stop_err_s;

    // Two-flop synchronizer on the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rxd;
            s2_q <= s1_q;
        end
    end

    // Frame sequencing: mid-bit sampling driven by the per-bit counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        deliver_s  = 1'b0;
        stop_err_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (!s2_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = CNT_ZERO;
                    if (!s2_q) begin
                        state_d = ST_DATA;
                        idx_d   = IDX_ZERO;
                    end else begin
                        // Start bit did not last to mid-bit: treat as a glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    // Right shift so the first (LSB) bit ends up at bit 0.
                    shift_d = {s2_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_ZERO;
                    idx_d   = idx_q + IDX_ONE;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = CNT_ZERO;
                    // Leave at mid stop bit so a back-to-back start is caught.
                    if (s2_q) begin
                        deliver_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_err_s = 1'b1;
                        state_d    = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                cnt_d = CNT_ZERO;
                if (s2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
            end
        endcase
    end

    // Holding register, handshake and status pulse next-state.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        ferr_d  = stop_err_s;
        busy_d  = (state_d != ST_IDLE);
        if (deliver_s) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                // Consumer still holds the previous byte: drop the new one.
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus randomized frames, checked
// every cycle against a timeline model that samples the recorded line at the
// absolute edges T0+HALF+k*CLKS_PER_BIT.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int C   = 24;
    localparam int DB  = 8;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + (DB + 1) * C;   // 230 cycles from E0

    logic          clk;
    logic          reset;
    logic          rxd;
    logic [DB-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          frame_err_o;
    logic          overrun_o;
    logic          busy_o;

    uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .rxd(rxd),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    int ready_mode = 0;

    // Observed DUT activity (written only by the compare process).
    int ferr_total = 0, ovr_total = 0, busy_total = 0, vhigh_total = 0;
    int rise_total = 0, last_rise = -1;
    logic prev_valid = 1'b0;
    logic [7:0] acc_q[$];

    // Model state.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    int   m_phase = 0;        // 0 idle, 1 in frame, 2 break
    int   m_t0 = 0;
    logic [7:0] m_sh = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] acc_at(input int i);
        if (i >= 0 && i < acc_q.size()) return acc_q[i];
        return 8'hxx;
    endfunction

    // One clock edge of the reference model, using the pre-edge inputs.
    task automatic model_edge();
        logic s2;
        logic deliver;
        logic ferr;
        int rel;
        int k;
        s2 = m_s2;
        deliver = 1'b0;
        ferr = 1'b0;
        if (reset) begin
            m_phase = 0; m_valid = 1'b0; m_data = 8'h00;
            m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
            m_s1 = 1'b1; m_s2 = 1'b1;
        end else begin
            if (m_phase == 0) begin
                if (!s2) begin m_phase = 1; m_t0 = cyc; end
            end else if (m_phase == 1) begin
                rel = cyc - m_t0 - H;
                if (rel == 0) begin
                    if (s2) m_phase = 0;
                end else if (rel > 0 && rel % C == 0) begin
                    k = rel / C;
                    if (k <= DB) m_sh[k-1] = s2;
                    else if (s2) begin deliver = 1'b1; m_phase = 0; end
                    else begin ferr = 1'b1; m_phase = 2; end
                end
            end else begin
                if (s2) m_phase = 0;
            end
            m_ovr  = deliver && m_valid && !ready_i;
            m_ferr = ferr;
            if (deliver && (!m_valid || ready_i)) begin
                m_data = m_sh; m_valid = 1'b1;
            end else if (m_valid && ready_i) begin
                m_valid = 1'b0;
            end
            m_busy = (m_phase != 0);
            m_s2 = m_s1;
            m_s1 = rxd;
        end
    endtask

    // Model process: advances the edge counter and the model at each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_edge();
        end
    end

    // Compare process: checks every output against the model each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("valid_o", int'(valid_o), int'(m_valid));
                chk_v("data_o", data_o, m_data);
                chk("frame_err_o", int'(frame_err_o), int'(m_ferr));
                chk("overrun_o", int'(overrun_o), int'(m_ovr));
                chk("busy_o", int'(busy_o), int'(m_busy));
                if (frame_err_o) ferr_total++;
                if (overrun_o) ovr_total++;
                if (busy_o) busy_total++;
                if (valid_o) vhigh_total++;
                if (valid_o && !prev_valid) begin rise_total++; last_rise = cyc; end
                prev_valid = valid_o;
                if (valid_o && ready_i) acc_q.push_back(data_o);
            end
        end
    end

    // Consumer ready driver, selected by ready_mode.
    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1: ready_i = 1'b1;
                2: ready_i = ($urandom_range(0, 3) != 0);
                default: ready_i = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bitlen(input bit jit);
        if (jit) return $urandom_range(C - 1, C + 1);
        return C;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit jit);
        rxd = 1'b0;
        repeat (bitlen(jit)) tick();
        for (int i = 0; i < DB; i++) begin
            rxd = b[i];
            repeat (bitlen(jit)) tick();
        end
        rxd = stop_v;
        repeat (bitlen(jit)) tick();
    endtask

    task automatic pulse_ready();
        ready_mode = 1;
        tick();
        ready_mode = 0;
        tick();
        tick();
    endtask

    int e0, f0, o0, b0, v0, r0, a0;

    initial begin
        reset = 1'b1;
        rxd = 1'b1;
        tick();
        cmp_en = 1'b1;
        repeat (4) tick();
        chk("reset valid_o", int'(valid_o), 0);
        chk_v("reset data_o", data_o, 8'h00);
        chk("reset busy_o", int'(busy_o), 0);
        reset = 1'b0;
        repeat (100) tick();

        // Defaults-style frame 0xFA, consumer idle, then one accept.
        f0 = ferr_total; o0 = ovr_total; r0 = rise_total; a0 = acc_q.size();
        e0 = cyc + 1;
        send_frame(8'hFA, 1'b1, 1'b0);
        chk("fa latency", last_rise - e0, LAT);
        chk("fa rises", rise_total - r0, 1);
        chk_v("fa data_o", data_o, 8'hFA);
        chk("fa errs", (ferr_total - f0) + (ovr_total - o0), 0);
        pulse_ready();
        chk("fa valid after accept", int'(valid_o), 0);
        chk_v("fa accepted", acc_at(a0), 8'hFA);
        repeat (10) tick();

        // Glitch shorter than half a bit.
        b0 = busy_total; r0 = rise_total; f0 = ferr_total;
        rxd = 1'b0;
        repeat (10) tick();
        rxd = 1'b1;
        repeat (40) tick();
        chk("glitch busy cycles", busy_total - b0, H);
        chk("glitch no valid", rise_total - r0, 0);
        chk("glitch no ferr", ferr_total - f0, 0);

        // Framing error followed by a long low line.
        f0 = ferr_total; r0 = rise_total;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (200) tick();
        chk("break busy", int'(busy_o), 1);
        rxd = 1'b1;
        repeat (10) tick();
        chk("ferr pulses", ferr_total - f0, 1);
        chk("ferr no valid", rise_total - r0, 0);
        chk("break exit busy", int'(busy_o), 0);

        // Overrun: second byte dropped while the first is held.
        o0 = ovr_total; a0 = acc_q.size();
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hA7, 1'b1, 1'b0);
        repeat (5) tick();
        chk_v("ovr data_o", data_o, 8'h3C);
        chk("ovr valid held", int'(valid_o), 1);
        chk("ovr pulses", ovr_total - o0, 1);
        pulse_ready();
        chk("ovr valid after accept", int'(valid_o), 0);
        chk_v("ovr accepted", acc_at(a0), 8'h3C);

        // Simultaneous accept with ready held high.
        ready_mode = 1;
        o0 = ovr_total; v0 = vhigh_total; a0 = acc_q.size();
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (5) tick();
        chk("acc count", acc_q.size() - a0, 3);
        chk("acc valid cycles", vhigh_total - v0, 3);
        chk("acc no ovr", ovr_total - o0, 0);
        chk_v("acc byte0", acc_at(a0), 8'h01);
        chk_v("acc byte1", acc_at(a0 + 1), 8'h80);
        chk_v("acc byte2", acc_at(a0 + 2), 8'hFF);

        // Reset during data bit 3 of 0xC3, then a clean 0x5A.
        f0 = ferr_total; o0 = ovr_total; a0 = acc_q.size();
        rxd = 1'b0; repeat (C) tick();
        rxd = 1'b1; repeat (C) tick();
        rxd = 1'b1; repeat (C) tick();
        rxd = 1'b0; repeat (C) tick();
        rxd = 1'b0; repeat (H) tick();
        rxd = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (5) tick();
        chk("rst acc count", acc_q.size() - a0, 1);
        chk_v("rst byte", acc_at(a0), 8'h5A);
        chk("rst no errs", (ferr_total - f0) + (ovr_total - o0), 0);

        // Randomized traffic: jittered frames, bad stops, glitches, random ready.
        ready_mode = 2;
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                rxd = 1'b0;
                repeat ($urandom_range(1, H - 2)) tick();
                rxd = 1'b1;
            end else if (kind == 1) begin
                send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
                repeat ($urandom_range(0, 30)) tick();
                rxd = 1'b1;
            end else begin
                send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
            end
            repeat ($urandom_range(0, 40)) tick();
        end
        ready_mode = 1;
        rxd = 1'b1;
        repeat (60) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
